// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, largest legal digit, FSM state type and
// the digit-valid check used by both the converter and the display splitter.
package bcd_pkg;

  localparam int          DIGIT_W = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // A BCD digit is legal when it lies in 0..9.
  function automatic logic digit_valid(input logic [DIGIT_W-1:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage : bcd_pkg

// File: rtl/bcd_to_bin_seq_mul10_add.sv
// Combinational acc*10 + d built from two shifts and adds (no multiplier).
// The result wraps to W bits.
module mul10_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] acc,
  input  logic [3:0]   d,
  output logic [W-1:0] y
);

  logic [W-1:0] d_ext_s;

  // Zero-extend the digit, then form (acc<<3) + (acc<<1) + d.
  always_comb begin
    d_ext_s = {{(W-4){1'b0}}, d};
    y       = (acc << 3) + (acc << 1) + d_ext_s;
  end

endmodule : mul10_add

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter. Latches NDIGITS packed digits on start,
// then folds one digit per clock (MSD first) into acc = acc*10 + digit.
// total/err update together with a one-cycle done pulse; any digit > 9 forces
// total to 0 and raises err while keeping the same fixed latency.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   bcd_in,
  output logic                   busy,
  output logic                   done,
  output logic [W-1:0]           total,
  output logic                   err
);

  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic                   load_s;
  logic                   step_s;
  logic                   finish_s;

  logic [4*NDIGITS-1:0]   dig_r;
  logic [W-1:0]           acc_r;
  logic [IDX_W-1:0]       idx_r;
  logic                   err_pend_r;
  logic [W-1:0]           total_r;
  logic                   err_r;
  logic                   done_r;
  logic                   busy_r;

  logic                   bad_in_s;
  logic [3:0]             cur_digit_s;
  logic [W-1:0]           mac_s;

  // Flag any illegal digit on the incoming word so it can be latched on start.
  always_comb begin
    bad_in_s = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      bad_in_s = bad_in_s | ~digit_valid(bcd_in[4*i +: 4]);
    end
  end

  // Select the latched digit addressed by the current index.
  always_comb begin
    cur_digit_s = 4'd0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx_r == IDX_W'(i)) begin
        cur_digit_s = dig_r[4*i +: 4];
      end else begin
        cur_digit_s = cur_digit_s;
      end
    end
  end

  mul10_add #(.W(W)) u_mul10_add (
    .acc (acc_r),
    .d   (cur_digit_s),
    .y   (mac_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and datapath strobes: load on accepted start, step every CONV
  // cycle, finish on the step that consumes digit 0.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s      = 1'b1;
          state_nxt_s = CONV;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CONV: begin
        step_s = 1'b1;
        if (idx_r == {IDX_W{1'b0}}) begin
          finish_s    = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = CONV;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Digit latch, accumulator, index counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_r      <= {(4*NDIGITS){1'b0}};
      acc_r      <= {W{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      err_pend_r <= 1'b0;
      total_r    <= {W{1'b0}};
      err_r      <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (load_s) begin
        dig_r      <= bcd_in;
        acc_r      <= {W{1'b0}};
        idx_r      <= IDX_W'(NDIGITS - 1);
        err_pend_r <= bad_in_s;
        busy_r     <= 1'b1;
      end else if (step_s) begin
        acc_r <= mac_s;
        if (finish_s) begin
          total_r <= err_pend_r ? {W{1'b0}} : mac_s;
          err_r   <= err_pend_r;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
        end else begin
          idx_r <= idx_r - {{(IDX_W-1){1'b0}}, 1'b1};
        end
      end else begin
        acc_r <= acc_r;
      end
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign total = total_r;
  assign err   = err_r;

endmodule : bcd_to_bin_seq

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: stimulus pushes expected results with
// the cycle in which done must appear; a negedge monitor pops on every done.
module tb_bcd_to_bin_seq;

  localparam int ND = 4;
  localparam int W  = 16;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [4*ND-1:0] bcd_in;
  logic            busy;
  logic            done;
  logic [W-1:0]    total;
  logic            err;

  typedef struct {
    logic [W-1:0] t;
    logic         e;
    int           c;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;

  bcd_to_bin_seq #(.NDIGITS(ND), .W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bcd_in (bcd_in),
    .busy   (busy),
    .done   (done),
    .total  (total),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter: value after edge k is k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected none (total=%0d t=%0t)", total, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("total", 32'(total), 32'(e.t));
        chk("err", 32'(err), 32'(e.e));
        chk("done_cycle", 32'(cyc), 32'(e.c));
      end
    end
  end

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic convert(input logic [4*ND-1:0] v, input logic [W-1:0] t, input logic e);
    @(negedge clk);
    bcd_in = v;
    start  = 1'b1;
    sb.push_back('{t: t, e: e, c: cyc + 1 + ND});
    @(negedge clk);
    start = 1'b0;
    chk("busy_run", 32'(busy), 32'd1);
    wait_drain(20);
    chk("busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_total", 32'(total), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    convert(16'h1234, 16'd1234, 1'b0);
    convert(16'h9999, 16'd9999, 1'b0);
    convert(16'h0000, 16'd0, 1'b0);
    convert(16'h0009, 16'd9, 1'b0);
    convert(16'h1000, 16'd1000, 1'b0);

    convert(16'h12A4, 16'd0, 1'b1);
    repeat (3) @(negedge clk);
    chk("err_hold", 32'(err), 32'd1);
    chk("total_hold", 32'(total), 32'd0);
    convert(16'h0059, 16'd59, 1'b0);

    // Input change after latch and start pulse during busy are both ignored.
    @(negedge clk);
    bcd_in = 16'h1234;
    start  = 1'b1;
    sb.push_back('{t: 16'd1234, e: 1'b0, c: cyc + 1 + ND});
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 16'h8888;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain(20);
    repeat (10) @(negedge clk);

    // Start held high: two conversions, done pulses 5 cycles apart.
    begin
      int c0;
      @(negedge clk);
      bcd_in = 16'h0042;
      start  = 1'b1;
      c0 = cyc + 1;
      sb.push_back('{t: 16'd42, e: 1'b0, c: c0 + ND});
      sb.push_back('{t: 16'd777, e: 1'b0, c: c0 + 2*ND + 1});
      while (cyc < c0 + ND) @(negedge clk);
      bcd_in = 16'h0777;
      while (cyc < c0 + ND + 1) @(negedge clk);
      start = 1'b0;
      wait_drain(20);
    end
    repeat (4) @(negedge clk);

    // Reset in the middle of a conversion: no done, outputs cleared at once.
    @(negedge clk);
    bcd_in = 16'h4321;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_total", 32'(total), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_total", 32'(total), 32'd0);
    convert(16'h4321, 16'd4321, 1'b0);

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1);
  end

endmodule : tb_bcd_to_bin_seq

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Sequential BCD-to-binary converter; the inverse of the display digit splitter.
- Takes NDIGITS packed BCD digits (e.g. thousands/hundreds/tens/ones from the clock's set-time digit editors) and produces the binary total used by the counter/compare logic.
- Multiply-by-10-and-add, one digit per clock, MSD first; start/busy/done handshake to the clock control FSM.

Parameters:
- NDIGITS, 4, number of BCD digits converted per request (1..4).
- W, 16, binary output width; must satisfy 2^W > 10^NDIGITS - 1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- bcd_in  input  4*NDIGITS  packed digits; [4*NDIGITS-1 -: 4] = MSD (thousands), [3:0] = ones.
- busy  output  1  high while converting.
- done  output  1  one-cycle pulse when total/err are updated.
- total  output  W  binary result; held between conversions.
- err  output  1  high if any latched digit was > 9; held with total.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, err=0, total=0; internal acc, index, and digit latch = 0.
- States: IDLE, CONV.
- IDLE:
  - start=1 at a rising edge: latch bcd_in into an internal register; acc=0; idx=NDIGITS-1; err_pending = (any latched digit > 9); go to CONV; busy=1 from the next cycle.
  - start=0: remain in IDLE with outputs held.
- CONV, each edge:
  - acc <= acc*10 + digit[idx], computed as (acc<<3)+(acc<<1)+digit, truncated to W bits; idx decrements.
  - When idx==0 at the edge:
    - total <= err_pending ? 0 : (acc*10 + digit[0]);
    - err <= err_pending; done <= 1 for exactly one cycle; busy <= 0; return to IDLE.
- Latency: start sampled at edge E0; done/total/err valid after edge E0+NDIGITS (4 cycles at default). The latency is fixed regardless of err.
- Input handling:
  - bcd_in changes after the latch edge have no effect on the running conversion.
  - start while busy=1 is ignored; it is not queued.
  - start asserted in the same cycle done is high is accepted: the FSM is in IDLE then. done is not asserted again until the new conversion completes.
  - start held high continuously gives back-to-back conversions, each NDIGITS+1 cycles apart (IDLE cycle plus NDIGITS CONV cycles).
- Output hold: total and err change only on the done edge. err clears only when a later valid conversion completes.
- Arithmetic: acc is W bits wide. With the parameter constraint there is no overflow for valid digits. Invalid digits (10..15) may wrap acc, but the result is discarded (total=0).
- Reset mid-conversion: immediate return to the reset state; no done pulse; the partial acc is discarded.

Decomposition:
- Shared package bcd_pkg:
  - DIGIT_W=4, BCD_MAX=4'd9;
  - state enum {IDLE, CONV};
  - a digit-valid check function (digit <= BCD_MAX). The display splitter uses the same check.
- One combinational sub-module, mul10_add:
  - inputs acc[W-1:0], d[3:0]; output acc*10+d using shift-add with no multiplier.
  - Reusable by the splitter's verification model.
- The FSM, index counter, and digit latch stay in bcd_to_bin_seq.

Test Plan:
- Reset then idle: rst_n low mid-run → busy=0, done=0, total=0, err=0 immediately; no done pulse after release until a start.
- Basic conversion: bcd_in=16'h1234 with start for one cycle → busy for 4 cycles; done pulse at start-edge+4; total=1234, err=0.
- Extremes: 16'h9999 → total=9999; 16'h0000 → total=0; 16'h0009 → 9; 16'h1000 → 1000.
- Invalid digit: bcd_in=16'h12A4 → done at +4, total=0, err=1. A following 16'h0059 → total=59, err=0.
- Protocol: start pulsed again at +2 cycles is ignored (only one done). bcd_in changed to 16'h8888 at +1 still gives total=1234. start held high over two conversions gives done pulses 5 cycles apart.
- Reset mid-operation: assert rst_n low at +2 during a 16'h4321 conversion → no done pulse, total stays 0. A fresh start after release gives 4321 at +4.
